// File: rtl/hb_tx_arbiter.sv
// Arbitrates the UART transmitter between hexbus packets and console bytes.
// Hexbus packets are never split; console bursts are bounded while hexbus waits.
module hb_tx_arbiter #(
   parameter int CON_BURST = 4,
   parameter int LGTIMEOUT = 8
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_hb_stb,
   input  logic [7:0] i_hb_byte,
   output logic       o_hb_busy,
   input  logic       i_con_stb,
   input  logic [6:0] i_con_data,
   output logic       o_con_busy,
   output logic       o_tx_stb,
   output logic [7:0] o_tx_data,
   input  logic       i_tx_busy,
   output logic [1:0] o_owner
);

   localparam int CW = $clog2(CON_BURST + 1);
   localparam logic [CW-1:0] BMAX = CW'(CON_BURST);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HB   = 2'b01,
      S_CON  = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic                 last_con_q, last_con_d;
   logic [CW-1:0]        burst_q, burst_d;
   logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
   logic                 tx_stb_q, tx_stb_d;
   logic [7:0]           tx_data_q, tx_data_d;

   logic                 free;
   logic                 grant_hb, grant_con;
   logic                 hb_xfer, con_xfer;
   logic                 hb_nl;
   logic [CW-1:0]        cnt_base, cnt_next;
   logic                 con_done;
   logic [LGTIMEOUT-1:0] tmo_inc;
   logic                 tmo_hit;
   logic                 hb_b7_unused;

   assign hb_b7_unused = i_hb_byte[7];

   always_comb begin
      free      = !tx_stb_q || !i_tx_busy;
      hb_nl     = (i_hb_byte[6:0] == 7'h0a);
      grant_hb  = 1'b0;
      grant_con = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant_hb  = i_hb_stb && (!i_con_stb || last_con_q);
            grant_con = i_con_stb && !grant_hb;
         end
         S_HB:    grant_hb  = 1'b1;
         S_CON:   grant_con = 1'b1;
         default: ;
      endcase
      hb_xfer  = i_hb_stb && free && grant_hb;
      con_xfer = i_con_stb && free && grant_con;

      // Burst count restarts at zero whenever a console grant begins
      cnt_base = (state_q == S_CON) ? burst_q : '0;
      cnt_next = (con_xfer && cnt_base != BMAX) ? cnt_base + 1'b1 : cnt_base;
      con_done = (cnt_next == BMAX) && i_hb_stb;

      tmo_inc = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
      tmo_hit = &tmo_inc;
   end

   always_comb begin
      state_d    = state_q;
      last_con_d = last_con_q;
      burst_d    = burst_q;
      tmo_d      = tmo_q;
      case (state_q)
         S_IDLE: begin
            tmo_d   = '0;
            burst_d = cnt_next;
            if (grant_hb) begin
               state_d = S_HB;
               if (hb_xfer && hb_nl) begin
                  last_con_d = 1'b0;
                  burst_d    = '0;
                  state_d    = i_con_stb ? S_CON : S_IDLE;
               end
            end else if (grant_con) begin
               state_d    = con_done ? S_IDLE : S_CON;
               last_con_d = last_con_q || con_done;
            end
         end
         S_HB: begin
            burst_d = '0;
            if (hb_xfer) begin
               tmo_d = '0;
               if (hb_nl) begin
                  last_con_d = 1'b0;
                  state_d    = i_con_stb ? S_CON : S_IDLE;
               end
            end else if (!i_hb_stb) begin
               tmo_d = tmo_inc;
               if (tmo_hit) begin
                  last_con_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end
         S_CON: begin
            burst_d = cnt_next;
            if (!i_con_stb || con_done) begin
               last_con_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output holds while UART is busy, refills in the drain cycle
   always_comb begin
      tx_stb_d  = tx_stb_q && i_tx_busy;
      tx_data_d = tx_data_q;
      if (hb_xfer) begin
         tx_stb_d  = 1'b1;
         tx_data_d = {1'b1, i_hb_byte[6:0]};
      end else if (con_xfer) begin
         tx_stb_d  = 1'b1;
         tx_data_d = {1'b0, i_con_data};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         last_con_q <= 1'b1;
         burst_q    <= '0;
         tmo_q      <= '0;
         tx_stb_q   <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_con_q <= last_con_d;
         burst_q    <= burst_d;
         tmo_q      <= tmo_d;
         tx_stb_q   <= tx_stb_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign o_hb_busy  = !(free && grant_hb);
   assign o_con_busy = !(free && grant_con);
   assign o_tx_stb   = tx_stb_q;
   assign o_tx_data  = tx_data_q;
   assign o_owner    = state_q;

endmodule

// File: tb/tb_hb_tx_arbiter.sv
// Bench for hb_tx_arbiter: directed scenarios plus random traffic,
// with an acceptance-order scoreboard and arbitration rule checks.
module tb_hb_tx_arbiter;

   localparam int CB  = 4;
   localparam int LG  = 8;
   localparam int TMO = (1 << LG) - 1;

   logic       clk;
   logic       rst_n;
   logic       i_hb_stb;
   logic [7:0] i_hb_byte;
   logic       o_hb_busy;
   logic       i_con_stb;
   logic [6:0] i_con_data;
   logic       o_con_busy;
   logic       o_tx_stb;
   logic [7:0] o_tx_data;
   logic       i_tx_busy;
   logic [1:0] o_owner;

   int checks = 0;
   int errors = 0;

   hb_tx_arbiter #(.CON_BURST(CB), .LGTIMEOUT(LG)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_hb_stb   (i_hb_stb),
      .i_hb_byte  (i_hb_byte),
      .o_hb_busy  (o_hb_busy),
      .i_con_stb  (i_con_stb),
      .i_con_data (i_con_data),
      .o_con_busy (o_con_busy),
      .o_tx_stb   (o_tx_stb),
      .o_tx_data  (o_tx_data),
      .i_tx_busy  (i_tx_busy),
      .o_owner    (o_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   // Scoreboard: every accepted source byte is expected on the UART in order
   logic [7:0] expq[$];
   logic       prev_hold;
   logic [7:0] prev_data;
   bit         in_pkt;
   int         con_run;
   int         hb_idle;
   logic       ha, ca;
   logic [7:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         prev_hold = 1'b0;
         in_pkt    = 1'b0;
         con_run   = 0;
         hb_idle   = 0;
      end else begin
         if (prev_hold) begin
            chk("hold_stb", o_tx_stb, 1);
            chk("hold_data", o_tx_data, prev_data);
         end
         prev_hold = o_tx_stb && i_tx_busy;
         prev_data = o_tx_data;
         if (o_tx_stb && !i_tx_busy) begin
            chk("tx_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("tx_data", o_tx_data, e);
            end
         end
         ha = i_hb_stb && !o_hb_busy;
         ca = i_con_stb && !o_con_busy;
         if (ha || ca) chk("one_grant", ha && ca, 0);
         if (ca) begin
            chk("pkt_split", in_pkt && hb_idle < TMO, 0);
            if (i_hb_stb) con_run++;
            chk("con_burst", con_run > CB, 0);
            expq.push_back({1'b0, i_con_data});
         end
         if (ha) begin
            expq.push_back({1'b1, i_hb_byte[6:0]});
            in_pkt  = (i_hb_byte[6:0] != 7'h0a);
            hb_idle = 0;
            con_run = 0;
         end else if (!i_hb_stb && hb_idle < 100000) begin
            hb_idle++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hb_send(input logic [7:0] b);
      int n = 0;
      i_hb_stb  = 1'b1;
      i_hb_byte = b;
      @(negedge clk);
      while (o_hb_busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("hb_accept", o_hb_busy, 0);
      cyc();
      i_hb_stb = 1'b0;
   endtask

   task automatic con_send(input logic [6:0] c);
      int n = 0;
      i_con_stb  = 1'b1;
      i_con_data = c;
      @(negedge clk);
      while (o_con_busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("con_accept", o_con_busy, 0);
      cyc();
      i_con_stb = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   logic [7:0] pkt3 [3];
   int         k;
   bit         found;
   logic [1:0] own_at;
   bit         stable;
   int         hb_i, hb_n, con_n, exp_hb, per, rem;
   bit         ha_t, ca_t;
   bit         hb_done, con_done;

   initial begin
      pkt3 = '{8'h41, 8'h31, 8'h0a};
      rst_n = 1'b0;
      i_hb_stb = 1'b0;
      i_hb_byte = '0;
      i_con_stb = 1'b0;
      i_con_data = '0;
      i_tx_busy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_stb", o_tx_stb, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_owner", o_owner, 0);
      chk("rst_hb_busy", o_hb_busy, 1);
      cyc();
      rst_n = 1'b1;

      // Hexbus "A1\n" at full rate
      i_hb_stb = 1'b1;
      i_hb_byte = 8'h41;
      @(negedge clk);
      chk("t1_acc0", o_hb_busy, 0);
      chk("t1_own_idle", o_owner, 0);
      cyc();
      i_hb_byte = 8'h31;
      @(negedge clk);
      chk("t1_tx0", o_tx_data, 8'hc1);
      chk("t1_stb0", o_tx_stb, 1);
      chk("t1_own_hb", o_owner, 2'b01);
      chk("t1_acc1", o_hb_busy, 0);
      cyc();
      i_hb_byte = 8'h0a;
      @(negedge clk);
      chk("t1_tx1", o_tx_data, 8'hb1);
      chk("t1_acc2", o_hb_busy, 0);
      cyc();
      i_hb_stb = 1'b0;
      @(negedge clk);
      chk("t1_tx2", o_tx_data, 8'h8a);
      chk("t1_stb2", o_tx_stb, 1);
      chk("t1_own_end", o_owner, 0);
      cyc();
      @(negedge clk);
      chk("t1_drained", o_tx_stb, 0);
      cyc();

      // Console byte arrives mid-packet
      i_hb_stb = 1'b1;
      i_hb_byte = 8'h41;
      cyc();
      i_hb_byte = 8'h31;
      i_con_stb = 1'b1;
      i_con_data = 7'h78;
      @(negedge clk);
      chk("t2_con_blk0", o_con_busy, 1);
      cyc();
      i_hb_byte = 8'h0a;
      @(negedge clk);
      chk("t2_con_blk1", o_con_busy, 1);
      chk("t2_nl_acc", o_hb_busy, 0);
      cyc();
      i_hb_stb = 1'b0;
      @(negedge clk);
      chk("t2_con_acc", o_con_busy, 0);
      chk("t2_tx_nl", o_tx_data, 8'h8a);
      chk("t2_own_con", o_owner, 2'b10);
      cyc();
      i_con_stb = 1'b0;
      @(negedge clk);
      chk("t2_tx_con", o_tx_data, 8'h78);
      chk("t2_stb_con", o_tx_stb, 1);
      repeat (3) cyc();

      // Stalled hexbus grant times out
      hb_send(8'h41);
      hb_send(8'h42);
      i_con_stb = 1'b1;
      i_con_data = 7'h55;
      k = 0;
      found = 1'b0;
      own_at = 2'b00;
      while (!found && k < 600) begin
         @(negedge clk);
         k++;
         if (!o_con_busy) found = 1'b1;
         else if (k == TMO) own_at = o_owner;
      end
      // release registered on the TMO-th edge after the last hexbus xfer
      chk("t4_own_before", own_at, 2'b01);
      chk("t4_release_cyc", k, TMO + 1);
      chk("t4_own_idle", o_owner, 0);
      cyc();
      i_con_stb = 1'b0;
      repeat (3) cyc();

      // UART backpressure holds the output
      i_tx_busy = 1'b1;
      i_hb_stb = 1'b1;
      i_hb_byte = 8'h41;
      cyc();
      i_hb_byte = 8'h42;
      i_con_stb = 1'b1;
      i_con_data = 7'h7a;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (o_tx_stb !== 1'b1 || o_tx_data !== 8'hc1 ||
             o_hb_busy !== 1'b1 || o_con_busy !== 1'b1) stable = 1'b0;
         cyc();
      end
      chk("t5_stable", stable, 1);
      i_tx_busy = 1'b0;
      @(negedge clk);
      chk("t5_rel_acc", o_hb_busy, 0);
      chk("t5_con_blk", o_con_busy, 1);
      cyc();
      i_hb_byte = 8'h0a;
      @(negedge clk);
      chk("t5_tx_next", o_tx_data, 8'hc2);
      cyc();
      i_hb_stb = 1'b0;
      @(negedge clk);
      chk("t5_con_acc", o_con_busy, 0);
      cyc();
      i_con_stb = 1'b0;
      repeat (3) cyc();

      // Reset mid-packet with a pending output byte
      i_hb_stb = 1'b1;
      i_hb_byte = 8'h0a;
      cyc();
      i_hb_byte = 8'h41;
      @(negedge clk);
      chk("t6_acc", o_hb_busy, 0);
      cyc();
      i_hb_stb = 1'b0;
      i_tx_busy = 1'b1;
      chk("t6_pending", o_tx_stb, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_stb", o_tx_stb, 0);
      chk("t6_async_own", o_owner, 0);
      i_tx_busy = 1'b0;
      i_hb_stb = 1'b1;
      i_hb_byte = 8'h41;
      i_con_stb = 1'b1;
      i_con_data = 7'h79;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t6_hb_first", o_hb_busy, 0);
      chk("t6_con_wait", o_con_busy, 1);
      cyc();
      i_hb_byte = 8'h0a;
      @(negedge clk);
      chk("t6_nl_acc", o_hb_busy, 0);
      cyc();
      i_hb_stb = 1'b0;
      @(negedge clk);
      chk("t6_con_after", o_con_busy, 0);
      cyc();
      i_con_stb = 1'b0;
      repeat (3) cyc();

      // Both sources stream continuously: 3-byte packet then CB console bytes
      hb_i = 0;
      hb_n = 0;
      con_n = 0;
      i_hb_stb = 1'b1;
      i_hb_byte = pkt3[0];
      i_con_stb = 1'b1;
      i_con_data = 7'($urandom);
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         ha_t = !o_hb_busy;
         ca_t = !o_con_busy;
         if (ha_t) hb_n++;
         if (ca_t) con_n++;
         cyc();
         if (ha_t) begin
            hb_i = (hb_i + 1) % 3;
            i_hb_byte = pkt3[hb_i];
         end
         if (ca_t) i_con_data = 7'($urandom);
      end
      per = 3 + CB;
      rem = 1000 % per;
      exp_hb = (1000 / per) * 3 + ((rem < 3) ? rem : 3);
      chk("t3_hb_bytes", hb_n, exp_hb);
      chk("t3_con_bytes", con_n, 1000 - exp_hb);
      i_con_stb = 1'b0;
      while (hb_i != 0) begin
         hb_send(pkt3[hb_i]);
         hb_i = (hb_i + 1) % 3;
      end
      i_hb_stb = 1'b0;
      repeat (3) cyc();

      // Random traffic with random UART backpressure
      hb_done = 1'b0;
      con_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 25; p++) begin
               for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
                  hb_send({1'($urandom), 7'($urandom_range(32, 126))});
                  repeat ($urandom_range(0, 2)) cyc();
               end
               hb_send({1'($urandom), 7'h0a});
               repeat ($urandom_range(0, 5)) cyc();
            end
            hb_done = 1'b1;
         end
         begin
            for (int i = 0; i < 60; i++) begin
               con_send(7'($urandom));
               repeat ($urandom_range(0, 4)) cyc();
            end
            con_done = 1'b1;
         end
         begin
            while (!(hb_done && con_done)) begin
               cyc();
               i_tx_busy = ($urandom_range(0, 3) == 0);
            end
            i_tx_busy = 1'b0;
         end
      join
      repeat (6) cyc();
      @(negedge clk);
      chk("sb_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
